rf_read_arbiter: RTL

Round-robin arbiter that shares the single 32:1 register-file read port among several requesters (decode operand fetch, debug port, etc.). It grants one read per cycle, drives the 5-bit select of the read-port mux, and registers the returned word. The response is presented to the winning requester one cycle later. It sits between the requesters and the register-file read mux.

---
 rtl/rf_read_arbiter_if.sv | 23 ++
 rtl/rf_read_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/rf_read_arbiter_if.sv
// Requester-side bus of rf_read_arbiter: per-requester read request/grant
// and the shared one-cycle response.
interface rf_read_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port; one read per cycle,
// response registered one cycle later. Define RF_ARB_FWD_EN for same-cycle write forwarding.
module rf_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    rf_read_arbiter_if.slave  bus,
    output logic [AW-1:0]     rf_sel,
    input  logic [DW-1:0]     rf_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic            found;
    logic [PW-1:0]   gidx;
    logic            xfer;
    logic [DW-1:0]   rd_word;
    int              idx;

    // Scan requesters starting at the priority pointer; first valid one wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
    end

    assign xfer          = found & ~rst;
    assign bus.req_ready = xfer ? (NREQ'(1) << gidx) : '0;
    assign rf_sel        = xfer ? bus.req_addr[int'(gidx)*AW +: AW] : '0;

`ifdef RF_ARB_FWD_EN
    always_comb begin
        rd_word = rf_data;
        if (wr_en && (wr_addr == rf_sel)) begin
            rd_word = wr_data;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
    assign rd_word   = rf_data;
`endif

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (xfer) begin
            ptr_d       = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
            rsp_valid_d = NREQ'(1) << gidx;
            // Register 0 reads as zero regardless of the mux or any forwarded write.
            rsp_data_d  = (rf_sel == '0) ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
